uart_tx_arbiter: RTL

- Shares one uart_byte_tx instance among N byte requesters (e.g. rx echo path, status reporter, debug dumper).
- Round-robin grants one byte at a time, drives send_en/data_byte, and waits for tx_done.
- Inserts a configurable inter-byte guard gap and aborts a transfer when tx_done never arrives.
- Sits between the requesting blocks and the uart_byte_tx instance in the top level.

---
 rtl/uart_arb_pkg.sv | 17 +
 rtl/uart_tx_arbiter_rr.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter.
// FSM encodings and a counter-width helper.
package uart_arb_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LAUNCH    = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int cnt_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Rotating-priority search over the request vector.
// Starts at ptr+1 and wraps; purely combinational.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int PTR_W = cnt_w(N_REQ - 1)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    logic [N_REQ-1:0] sh;

    // First set request after the last winner, wrapping around.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sh     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            sh = req >> ((int'(ptr) + k) % N_REQ);
            if (!valid && sh[0]) begin
                winner = PTR_W'((int'(ptr) + k) % N_REQ);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_byte_tx among N_REQ byte requesters.
// Round-robin grant, launch, wait for done, guard gap.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 65535
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   ack,
    output logic [7:0]         tx_data_byte,
    output logic               tx_send_en,
    input  logic               tx_done,
    output logic               busy,
    output logic [2:0]         owner,
    output logic               timeout_err
);

    localparam int PTR_W   = cnt_w(N_REQ - 1);
    localparam int TIMER_W = cnt_w(TIMEOUT);
    localparam int GAP_W   = cnt_w(GAP_CYCLES);

    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam logic [1:0] AFTER_XFER =
        (GAP_CYCLES > 0) ? GAP : IDLE;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [TIMER_W-1:0] timer;
    logic [GAP_W-1:0]   gap_cnt;
    logic [PTR_W-1:0]   winner;
    logic               win_valid;
    logic               abort;
    logic [N_REQ-1:0]   grant_oh;
    logic [7:0]         win_byte;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (win_valid)
    );

    assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    assign win_byte = 8'(req_data >> {winner, 3'b000});

    // Next-state decode; tx_done beats a same-cycle timeout.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_valid)
                    state_nxt = LAUNCH;
            end
            LAUNCH: begin
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_nxt = AFTER_XFER;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = AFTER_XFER;
                    abort     = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= PTR_W'(N_REQ - 1);
            timer        <= '0;
            gap_cnt      <= '0;
            ack          <= '0;
            tx_data_byte <= '0;
            tx_send_en   <= 1'b0;
            busy         <= 1'b0;
            owner        <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != IDLE);
            ack         <= '0;
            tx_send_en  <= 1'b0;
            timeout_err <= abort;

            if (state == IDLE && win_valid) begin
                tx_data_byte <= win_byte;
                owner        <= 3'(winner);
                ptr          <= winner;
                ack          <= grant_oh;
            end

            if (state == LAUNCH) begin
                tx_send_en <= 1'b1;
                timer      <= '0;
            end else if (state == WAIT_DONE && !tx_done) begin
                timer <= timer + 1'b1;
            end

            if (state == GAP)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
        end
    end

endmodule
